// File: rtl/qrisc32_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : risc_pack
// Brief   : Shared types and constants for the qrisc32 memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package risc_pack;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic [31:0] ARB_ERR_RDATA = 32'h0;

endpackage
`default_nettype wire

// File: rtl/qrisc32_mem_arb_starve.sv
`default_nettype none
// ============================================================================
// Module  : qrisc32_arb_starve
// Brief   : Saturating count of data grants made over a waiting fetch;
//           o_force_if hands the next grant to IF once the limit is hit.
// Revision: 1.0 - initial release
// ============================================================================
module qrisc32_arb_starve
    import risc_pack::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic areset,
    input  logic i_d_grant_contended,
    input  logic i_if_grant,
    output logic o_force_if
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (areset) begin
            r_cnt <= 4'd0;
        end else if (i_if_grant) begin
            r_cnt <= 4'd0;
        end else if (i_d_grant_contended && (r_cnt != 4'(STARVE_MAX))) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_force_if = (r_cnt == 4'(STARVE_MAX));

endmodule
`default_nettype wire

// File: rtl/qrisc32_mem_arb.sv
`default_nettype none
// ============================================================================
// Module  : qrisc32_mem_arb
// Brief   : Shares one single-port memory bus between instruction fetch and
//           the MEM stage. Optional bus watchdog: QRISC32_MEM_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module qrisc32_mem_arb
    import risc_pack::*;
#(
    parameter int STARVE_MAX = 4
`ifdef QRISC32_MEM_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        pipe_stall,
    output logic        bus_err
);

    arb_state_t r_state;
    logic       r_flush_pend;
    logic       w_force_if;
    logic       w_can_grant;
    logic       w_if_elig;
    logic       w_grant_d;
    logic       w_grant_i;
    logic       w_timeout;

    // The ack cycle is a turnaround: the acked requester still shows its old
    // request, so nothing is granted until the following cycle.
    assign w_can_grant = (r_state == IDLE) && !if_ack && !dm_ack;
    assign w_if_elig   = if_req && !flush;
    assign w_grant_d   = w_can_grant && dm_req && !(w_if_elig && w_force_if);
    assign w_grant_i   = w_can_grant && w_if_elig && !w_grant_d;

    qrisc32_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk                 (clk),
        .areset              (areset),
        .i_d_grant_contended (w_grant_d && if_req),
        .i_if_grant          (w_grant_i),
        .o_force_if          (w_force_if)
    );

`ifdef QRISC32_MEM_ARB_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_WD_W-1:0] r_wd_cnt;

    always_ff @(posedge clk) begin
        if (areset || (r_state == IDLE)) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state != IDLE) && !mem_ack &&
                       (r_wd_cnt == c_WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (areset) begin
            r_state      <= IDLE;
            r_flush_pend <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            if_ack       <= 1'b0;
            if_rdata     <= 32'h0;
            dm_ack       <= 1'b0;
            dm_rdata     <= 32'h0;
            bus_err      <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            dm_ack  <= 1'b0;
            bus_err <= w_timeout;
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state   <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_we ? dm_wdata : 32'h0;
                    end else if (w_grant_i) begin
                        r_state   <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= 32'h0;
                    end
                end
                BUSY_I: begin
                    if (mem_ack || w_timeout) begin
                        r_state      <= IDLE;
                        mem_req      <= 1'b0;
                        r_flush_pend <= 1'b0;
                        // A jump taken during the fetch makes its word stale.
                        if (!(r_flush_pend || flush)) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : ARB_ERR_RDATA;
                        end
                    end else if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ack || w_timeout) begin
                        r_state  <= IDLE;
                        mem_req  <= 1'b0;
                        dm_ack   <= 1'b1;
                        dm_rdata <= mem_ack ? mem_rdata : ARB_ERR_RDATA;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign pipe_stall = dm_req & ~dm_ack;

endmodule
`default_nettype wire

// File: tb/tb_qrisc32_mem_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_qrisc32_mem_arb
// Brief   : Directed and random self-checking bench for qrisc32_mem_arb.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_qrisc32_mem_arb;

    localparam int STARVE_MAX = 4;
    localparam int TO         = 8;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, flush = 1'b0;
    logic [31:0] if_addr = 32'h0, dm_addr = 32'h0, dm_wdata = 32'h0;
    logic        if_ack, dm_ack, mem_req, mem_we, pipe_stall, bus_err;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    qrisc32_mem_arb #(
        .STARVE_MAX (STARVE_MAX)
`ifdef QRISC32_MEM_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TO)
`endif
    ) u_dut (
        .clk (clk), .areset (areset),
        .if_req (if_req), .if_addr (if_addr), .if_ack (if_ack), .if_rdata (if_rdata),
        .dm_req (dm_req), .dm_we (dm_we), .dm_addr (dm_addr), .dm_wdata (dm_wdata),
        .dm_ack (dm_ack), .dm_rdata (dm_rdata), .flush (flush),
        .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata), .mem_ack (mem_ack),
        .pipe_stall (pipe_stall), .bus_err (bus_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus slave: word memory, ack after mem_lat cycles of mem_req (0 = never).
    logic [31:0] mem_arr [256];
    int          mem_lat  = 1;
    int          mem_cnt  = 0;
    bit          rand_lat = 1'b0;

    // Reference model: transaction-level view of who owns the bus.
    int          m_state = 0;      // 0 free, 1 fetch, 2 data
    bit          m_ack_i = 0, m_ack_d = 0, m_flushed = 0, m_err = 0;
    logic [31:0] m_rd_i = 0, m_rd_d = 0, m_addr = 0, m_wdata = 0;
    bit          m_we = 0;
    int          m_starve = 0, m_wd = 0;

    logic        s_rst, s_if_req, s_dm_req, s_dm_we, s_flush, s_mem_ack;
    logic [31:0] s_if_addr, s_dm_addr, s_dm_wdata, s_mem_rdata;

    int          stall_cnt = 0;
    logic        prev_mem_req = 1'b0;
    logic [31:0] grant_log[$];

    task automatic model_step();
        int old;
        bit ei, tmo, n_ai, n_ad, n_err;
        if (s_rst) begin
            m_state = 0; m_ack_i = 0; m_ack_d = 0; m_rd_i = 0; m_rd_d = 0;
            m_flushed = 0; m_starve = 0; m_wd = 0; m_err = 0;
            return;
        end
        old = m_state; n_ai = 0; n_ad = 0; n_err = 0; tmo = 0;
        if (m_state == 0) begin
            if (!m_ack_i && !m_ack_d) begin
                ei = s_if_req && !s_flush;
                if (s_dm_req && !(ei && m_starve == STARVE_MAX)) begin
                    m_state = 2; m_we = s_dm_we; m_addr = s_dm_addr;
                    m_wdata = s_dm_we ? s_dm_wdata : 32'h0;
                    if (s_if_req && m_starve < STARVE_MAX) m_starve++;
                end else if (ei) begin
                    m_state = 1; m_we = 0; m_addr = s_if_addr; m_wdata = 0; m_starve = 0;
                end
            end
        end else begin
`ifdef QRISC32_MEM_ARB_TIMEOUT_EN
            tmo = !s_mem_ack && (m_wd == TO - 1);
`endif
            if (m_state == 1 && s_flush) m_flushed = 1;
            if (s_mem_ack || tmo) begin
                if (m_state == 2) begin
                    n_ad = 1; m_rd_d = s_mem_ack ? s_mem_rdata : 32'h0;
                end else if (!m_flushed) begin
                    n_ai = 1; m_rd_i = s_mem_ack ? s_mem_rdata : 32'h0;
                end
                n_err = tmo; m_state = 0; m_flushed = 0;
            end
        end
        if (m_state == 0 || old == 0) m_wd = 0;
        else m_wd++;
        m_ack_i = n_ai; m_ack_d = n_ad; m_err = n_err;
    endtask

    task automatic tick();
        @(negedge clk);
        chk("pipe_stall", pipe_stall, dm_req & ~m_ack_d);
        if (pipe_stall) stall_cnt++;
        s_rst = areset; s_if_req = if_req; s_if_addr = if_addr; s_dm_req = dm_req;
        s_dm_we = dm_we; s_dm_addr = dm_addr; s_dm_wdata = dm_wdata; s_flush = flush;
        s_mem_ack = mem_ack; s_mem_rdata = mem_rdata;
        @(posedge clk);
        #1;
        model_step();
        chk("if_ack", if_ack, m_ack_i);
        chk("dm_ack", dm_ack, m_ack_d);
        chk("if_rdata", if_rdata, m_rd_i);
        chk("dm_rdata", dm_rdata, m_rd_d);
        chk("bus_err", bus_err, m_err);
        chk("mem_req", mem_req, m_state != 0);
        if (m_state != 0) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (mem_req && !prev_mem_req) grant_log.push_back(mem_addr);
        prev_mem_req = mem_req;
        if (mem_req) begin
            mem_cnt++;
            if (mem_lat != 0 && mem_cnt == mem_lat) begin
                mem_ack = 1'b1;
                mem_rdata = mem_arr[mem_addr[9:2]];
                if (mem_we) mem_arr[mem_addr[9:2]] = mem_wdata;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            mem_cnt = 0;
            mem_ack = 1'b0;
            if (rand_lat) mem_lat = $urandom_range(1, 5);
        end
    endtask

    // Waits for dm_ack, keeps the request through the ack cycle, then drops it.
    task automatic wait_dm(input int limit, output logic [31:0] rd, output int cyc);
        bit seen = 0;
        cyc = 0; rd = 32'hx;
        while (!seen && cyc < limit) begin
            tick(); cyc++;
            if (dm_ack) begin seen = 1; rd = dm_rdata; end
        end
        chk("dm_ack_seen", seen, 1'b1);
        tick();
        dm_req = 1'b0;
    endtask

    task automatic wait_if(input int limit, output logic [31:0] rd);
        bit seen = 0;
        int cyc = 0;
        rd = 32'hx;
        while (!seen && cyc < limit) begin
            tick(); cyc++;
            if (if_ack) begin seen = 1; rd = if_rdata; end
        end
        chk("if_ack_seen", seen, 1'b1);
        tick();
        if_req = 1'b0;
    endtask

    logic [31:0] rd;
    int          cyc;
    logic [31:0] exp_order [10];
    bit          last_if_ack, last_dm_ack;

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h5A000000 ^ (i * 32'h01010101);
        mem_arr[32'h100 >> 2] = 32'hCAFEF00D;

        // Reset state
        repeat (3) tick();
        areset = 1'b0;
        tick();
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_we", mem_we, 1'b0);

        // Single load, memory acks in the first mem_req cycle
        mem_lat = 1; stall_cnt = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        wait_dm(10, rd, cyc);
        chk("load_rdata", rd, 32'hCAFEF00D);
        chk("load_latency", cyc, 2);
        chk("load_stall_cycles", stall_cnt, 2);

        // Store, held on the bus for three cycles
        mem_lat = 3;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h12345678;
        tick();
        chk("store_mem_we", mem_we, 1'b1);
        chk("store_mem_addr", mem_addr, 32'h200);
        chk("store_mem_wdata", mem_wdata, 32'h12345678);
        wait_dm(10, rd, cyc);
        chk("store_latency", cyc, 3);
        chk("store_written", mem_arr[32'h200 >> 2], 32'h12345678);
        dm_we = 1'b0;

        // Starvation: both requesters held continuously from a fresh reset
        areset = 1'b1; tick(); areset = 1'b0;
        mem_lat = 1; grant_log.delete();
        dm_req = 1'b1; dm_addr = 32'h300; if_req = 1'b1; if_addr = 32'h40;
        for (int i = 0; i < 60 && grant_log.size() < 10; i++) tick();
        exp_order = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h40,
                      32'h300, 32'h300, 32'h300, 32'h300, 32'h40};
        chk("grant_count", grant_log.size(), 10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            chk($sformatf("grant_order[%0d]", i), grant_log[i], exp_order[i]);
        dm_req = 1'b0; if_req = 1'b0;
        repeat (4) tick();

        // Flush one cycle before mem_ack kills the fetch; the redirect at 0x80 completes
        mem_lat = 3;
        if_req = 1'b1; if_addr = 32'h40;
        tick(); tick();
        flush = 1'b1; if_addr = 32'h80;
        tick();
        flush = 1'b0;
        tick();
        chk("flushed_if_ack", if_ack, 1'b0);
        wait_if(12, rd);
        chk("refetch_rdata", rd, mem_arr[32'h80 >> 2]);

        // Reset two cycles into a five-cycle load, then the request is served again
        mem_lat = 5;
        dm_req = 1'b1; dm_addr = 32'h100;
        tick(); tick();
        areset = 1'b1;
        tick();
        chk("rst_mid_mem_req", mem_req, 1'b0);
        chk("rst_mid_dm_ack", dm_ack, 1'b0);
        areset = 1'b0;
        mem_lat = 2;
        wait_dm(12, rd, cyc);
        chk("post_rst_rdata", rd, 32'hCAFEF00D);

`ifdef QRISC32_MEM_ARB_TIMEOUT_EN
        // Memory never answers: watchdog completes the load with zero data
        mem_lat = 0;
        dm_req = 1'b1; dm_addr = 32'h104;
        wait_dm(20, rd, cyc);
        chk("timeout_latency", cyc, TO + 1);
        chk("timeout_rdata", rd, 32'h0);
`endif

        // Random traffic against the reference model
        rand_lat = 1'b1; mem_lat = 2;
        last_if_ack = 0; last_dm_ack = 0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            flush = 1'b0;
            if (dm_req) begin
                if (last_dm_ack) begin
                    dm_req = ($urandom_range(0, 1) == 1);
                    dm_we = $urandom_range(0, 1); dm_addr = {22'h0, 8'($urandom), 2'b00};
                    dm_wdata = $urandom;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                dm_req = 1'b1; dm_we = $urandom_range(0, 1);
                dm_addr = {22'h0, 8'($urandom), 2'b00}; dm_wdata = $urandom;
            end
            if (if_req) begin
                if (last_if_ack) begin
                    if_req = ($urandom_range(0, 3) != 0);
                    if_addr = {22'h0, 8'($urandom), 2'b00};
                end
            end else if ($urandom_range(0, 1) == 0) begin
                if_req = 1'b1; if_addr = {22'h0, 8'($urandom), 2'b00};
            end
            if ($urandom_range(0, 9) == 0) begin
                flush = 1'b1;
                if (if_req) if_addr = {22'h0, 8'($urandom), 2'b00};
            end
            last_if_ack = if_ack;
            last_dm_ack = dm_ack;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qrisc32_mem_arb.md
Name: qrisc32_mem_arb

Overview:
- Arbitrates one shared single-port memory bus between the instruction-fetch requester (IF) and the data-memory requester (MEM stage loads/stores).
- Sequences each bus transaction with a req/ack handshake.
- Drops fetch results made stale by a taken jump, using the flush input driven from EX new_address_valid.
- Generates pipe_stall for EX and the downstream pipeline while a data access is outstanding.

Parameters:
STARVE_MAX, 4, max consecutive data grants while if_req is pending before IF is forced a grant (1..15)
TIMEOUT_CYCLES, 64, bus watchdog limit in cycles; used only with the optional feature

Ports:
clk  in  1  clock, all logic on posedge
areset  in  1  reset; synchronous, active-high
if_req  in  1  fetch request; held until if_ack
if_addr  in  32  fetch address
if_ack  out  1  one-cycle pulse; fetch complete
if_rdata  out  32  fetched word; valid with if_ack
dm_req  in  1  data request; held until dm_ack
dm_we  in  1  1 = store, 0 = load
dm_addr  in  32  data address (EX-computed val_r1)
dm_wdata  in  32  store data
dm_ack  out  1  one-cycle pulse; data access complete
dm_rdata  out  32  load data; valid with dm_ack
flush  in  1  from EX new_address_valid; kills the in-flight/pending fetch result
mem_req  out  1  bus request; held until mem_ack
mem_we  out  1  bus write enable
mem_addr  out  32  bus address
mem_wdata  out  32  bus write data
mem_rdata  in  32  bus read data; valid with mem_ack
mem_ack  in  1  bus completion, single cycle
pipe_stall  out  1  stall to pipeline stages
bus_err  out  1  watchdog error pulse; constant 0 without the feature

Behaviour:
- Reset (areset high at a clk edge): state IDLE; all outputs 0; starvation counter 0; flush_pend 0. Reset mid-transaction drops it silently: mem_req low the next cycle, no ack to either requester.
- FSM states and transitions:
  - IDLE: requests sampled; on a grant latch addr/we/wdata into mem_* registers, go to BUSY_I or BUSY_D.
  - BUSY_x: mem_req=1; stays until mem_ack; on mem_ack capture mem_rdata, pulse x_ack for 1 cycle, return to IDLE.
- Latency: request seen in IDLE at cycle N → mem_req high at N+1 → mem_ack at cycle M (M ≥ N+1) → x_ack and x_rdata at M+1.
  - Minimum 2 cycles request-to-ack.
  - One IDLE cycle between back-to-back transactions.
- Priority:
  - Data wins when both are requesting, unless starve_cnt == STARVE_MAX; then IF wins.
  - starve_cnt increments on each data grant made while if_req=1, saturating at STARVE_MAX; clears on any IF grant.
- mem_we is 0 for IF; mem_wdata is don't-care for loads and is driven 0.
- Flush:
  - flush=1 in BUSY_I, or in the ack cycle of BUSY_I: the bus transaction still completes, but if_ack is suppressed.
  - flush=1 in IDLE with if_req=1: that IF request is not granted this cycle.
  - flush in BUSY_D has no effect.
- pipe_stall = dm_req & ~dm_ack (combinational), so the stage holding the load/store freezes until its ack cycle.
- x_rdata holds its last captured value between acks.

Optional Feature:
QRISC32_MEM_ARB_TIMEOUT_EN
- With the macro: a watchdog counter runs in BUSY_x.
  - If TIMEOUT_CYCLES cycles pass without mem_ack: drop mem_req, pulse x_ack with x_rdata = 32'h0, pulse bus_err for the same cycle, return to IDLE.
  - A flushed IF timeout pulses bus_err only.
- Without the macro: no counter; bus_err is tied 0; BUSY_x waits indefinitely.

Decomposition:
- Shared package risc_pack gets:
  - arb_state_t enum: IDLE, BUSY_I, BUSY_D.
  - ARB_ERR_RDATA = 32'h0.
- One sub-module is natural: qrisc32_arb_starve, the saturating starvation counter with its force-IF output. The watchdog stays inline.

Test Plan:
- Single load, dm_addr=0x100, memory returns 0xCAFEF00D one cycle after mem_req → dm_ack and dm_rdata=0xCAFEF00D 2 cycles after request; pipe_stall high for exactly those 2 cycles.
- if_req and dm_req both held continuously, STARVE_MAX=4, memory ack latency 1 → grant order D,D,D,D,I,D,D,D,D,I; if_ack after every 4th dm_ack.
- Fetch at 0x40 in BUSY_I, flush pulsed 1 cycle before mem_ack → bus completes, if_ack stays 0; next if_req at 0x80 is granted and acked normally.
- Store dm_we=1, addr=0x200, wdata=0x12345678 → mem_we=1, mem_addr=0x200, mem_wdata=0x12345678 held until mem_ack; dm_ack 1 cycle after.
- areset asserted 2 cycles into a 5-cycle data access → next cycle mem_req=0, no dm_ack, state IDLE; a new request after reset is served normally.
- With QRISC32_MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never acks a load → after 8 cycles dm_ack=1, dm_rdata=0, bus_err=1 for one cycle.
